bcd_time_counter: RTL and testbench

Parametrised cascade of two-digit BCD modulo counters forming a clock or time-of-day register, for example HH:MM:SS. Advances on a one-cycle enable tick from the prescaler. Supports synchronous validated load, hold, and wrap carry-out. Sits between the 1 Hz tick generator and the 7-segment display multiplexer. Generalises the earlier fixed two-nibble counter to N fields with per-field modulus.

---
 rtl/bcd_time_pkg.sv | 17 +
 rtl/bcd_field.sv | 77 +++++++
 rtl/bcd_time_counter.sv | 111 +++++++++++
 tb/tb_bcd_time_counter.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/bcd_time_pkg.sv
// rtl/bcd_time_pkg.sv - shared constants and BCD helpers for the BCD time counter
package bcd_time_pkg;

  localparam logic [3:0] BCD_DIGIT_MAX = 4'd9;
  localparam int         FIELD_W       = 8;
  localparam int         MOD_SEC       = 60;
  localparam int         MOD_MIN       = 60;
  localparam int         MOD_HOUR      = 24;

  // Two-digit BCD field to binary (tens*10 + ones); used to range-check loads.
  function automatic logic [7:0] bcd_to_bin(input logic [7:0] f);
    logic [7:0] t;
    t = {4'd0, f[7:4]};
    return (t << 3) + (t << 1) + {4'd0, f[3:0]};
  endfunction

endpackage

// File: rtl/bcd_field.sv
// rtl/bcd_field.sv - one two-digit modulo-MOD BCD counter field (down-count under COUNT_DOWN_EN)
module bcd_field
  import bcd_time_pkg::*;
#(
  parameter int MOD = 60
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               inc,
`ifdef COUNT_DOWN_EN
  input  logic               dec,
  output logic               at_zero,
`endif
  input  logic               load,
  input  logic [FIELD_W-1:0] load_val,
  output logic [FIELD_W-1:0] value,
  output logic               at_max
);

  localparam int         MAX_VAL  = MOD - 1;
  localparam logic [3:0] MAX_TENS = 4'(MAX_VAL / 10);
  localparam logic [3:0] MAX_ONES = 4'(MAX_VAL % 10);

  logic [3:0] tens_q, tens_d;
  logic [3:0] ones_q, ones_d;

  assign value  = {tens_q, ones_q};
  assign at_max = (tens_q == MAX_TENS) && (ones_q == MAX_ONES);
`ifdef COUNT_DOWN_EN
  assign at_zero = (tens_q == 4'd0) && (ones_q == 4'd0);
`endif

  // Next digit values: load wins, then increment (or decrement) with digit and field wrap.
  always_comb begin
    tens_d = tens_q;
    ones_d = ones_q;
    if (load) begin
      tens_d = load_val[7:4];
      ones_d = load_val[3:0];
    end else if (inc) begin
      if (at_max) begin
        tens_d = 4'd0;
        ones_d = 4'd0;
      end else if (ones_q == BCD_DIGIT_MAX) begin
        tens_d = tens_q + 4'd1;
        ones_d = 4'd0;
      end else begin
        ones_d = ones_q + 4'd1;
      end
    end
`ifdef COUNT_DOWN_EN
    else if (dec) begin
      if (at_zero) begin
        tens_d = MAX_TENS;
        ones_d = MAX_ONES;
      end else if (ones_q == 4'd0) begin
        tens_d = tens_q - 4'd1;
        ones_d = BCD_DIGIT_MAX;
      end else begin
        ones_d = ones_q - 4'd1;
      end
    end
`endif
  end

  // Digit registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tens_q <= 4'd0;
      ones_q <= 4'd0;
    end else begin
      tens_q <= tens_d;
      ones_q <= ones_d;
    end
  end

endmodule

// File: rtl/bcd_time_counter.sv
// rtl/bcd_time_counter.sv - N-field cascaded BCD time counter with validated load; COUNT_DOWN_EN adds dir
module bcd_time_counter
  import bcd_time_pkg::*;
#(
  parameter int                        N_FIELDS   = 3,
  parameter logic [8*N_FIELDS-1:0]     FIELD_MODS = {8'd24, 8'd60, 8'd60}
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    tick,
  input  logic                    hold,
  input  logic                    load,
`ifdef COUNT_DOWN_EN
  input  logic                    dir,
`endif
  input  logic [8*N_FIELDS-1:0]   load_val,
  output logic [8*N_FIELDS-1:0]   count_out,
  output logic                    carry_out,
  output logic                    load_err
);

  logic [N_FIELDS-1:0] at_max;
  logic [N_FIELDS-1:0] inc_v;
  logic                load_ok;
  logic                field_load;
  logic                tick_en;
  logic                run_up;
  logic [7:0]          fv;
  logic                carry_q, carry_d;
  logic                load_err_q, load_err_d;
`ifdef COUNT_DOWN_EN
  logic [N_FIELDS-1:0] at_zero;
  logic [N_FIELDS-1:0] dec_v;
  logic                run_dn;
`endif

  // Load is accepted only if every digit is decimal and every field is below its modulus.
  always_comb begin
    load_ok = 1'b1;
    fv      = 8'd0;
    for (int i = 0; i < N_FIELDS; i++) begin
      fv = load_val[8*i +: 8];
      if ((fv[7:4] > BCD_DIGIT_MAX) || (fv[3:0] > BCD_DIGIT_MAX) ||
          (bcd_to_bin(fv) >= FIELD_MODS[8*i +: 8]))
        load_ok = 1'b0;
    end
  end

  assign field_load = load & load_ok;
  // Any load, accepted or not, and hold both swallow the tick.
  assign tick_en    = tick & ~load & ~hold;

  // Ripple enables: field k moves only when every lower field sits at its wrap point.
  always_comb begin
`ifdef COUNT_DOWN_EN
    run_up = tick_en & ~dir;
    run_dn = tick_en & dir;
    dec_v  = '0;
`else
    run_up = tick_en;
`endif
    inc_v = '0;
    for (int k = 0; k < N_FIELDS; k++) begin
      inc_v[k] = run_up;
      run_up   = run_up & at_max[k];
`ifdef COUNT_DOWN_EN
      dec_v[k] = run_dn;
      run_dn   = run_dn & at_zero[k];
`endif
    end
`ifdef COUNT_DOWN_EN
    carry_d = run_up | run_dn;
`else
    carry_d = run_up;
`endif
    load_err_d = load & ~load_ok;
  end

  for (genvar gi = 0; gi < N_FIELDS; gi++) begin : g_field
    bcd_field #(
      .MOD(int'(FIELD_MODS[8*gi +: 8]))
    ) u_field (
      .clk     (clk),
      .rst_n   (rst_n),
      .inc     (inc_v[gi]),
`ifdef COUNT_DOWN_EN
      .dec     (dec_v[gi]),
      .at_zero (at_zero[gi]),
`endif
      .load    (field_load),
      .load_val(load_val[8*gi +: 8]),
      .value   (count_out[8*gi +: 8]),
      .at_max  (at_max[gi])
    );
  end

  // Registered status pulses aligned with the count they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry_q    <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      carry_q    <= carry_d;
      load_err_q <= load_err_d;
    end
  end

  assign carry_out = carry_q;
  assign load_err  = load_err_q;

endmodule

// File: tb/tb_bcd_time_counter.sv
// tb/tb_bcd_time_counter.sv - directed self-checking bench for bcd_time_counter
module tb_bcd_time_counter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tick = 1'b0;
  logic        hold = 1'b0;
  logic        load = 1'b0;
  logic        dir = 1'b0;
  logic [23:0] load_val = 24'h0;
  logic [23:0] count_out;
  logic        carry_out;
  logic        load_err;
  int          vectors = 0;
  int          miscompares = 0;

  always #5 clk = ~clk;

  bcd_time_counter dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .tick     (tick),
    .hold     (hold),
    .load     (load),
`ifdef COUNT_DOWN_EN
    .dir      (dir),
`endif
    .load_val (load_val),
    .count_out(count_out),
    .carry_out(carry_out),
    .load_err (load_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_load(input logic [23:0] v, input logic t);
    load     = 1'b1;
    load_val = v;
    tick     = t;
    step();
    load     = 1'b0;
    tick     = 1'b0;
  endtask

  task automatic test_reset();
    logic [23:0] exp_c;
    #2;
    vectors++; if (count_out !== 24'h000000) begin miscompares++; $display("FAIL reset_count: got %h want 000000", count_out); end
    vectors++; if (carry_out !== 1'b0) begin miscompares++; $display("FAIL reset_carry: got %b want 0", carry_out); end
    vectors++; if (load_err !== 1'b0) begin miscompares++; $display("FAIL reset_load_err: got %b want 0", load_err); end
    #4 rst_n = 1'b1;
    step();
    tick = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      step();
      exp_c = 24'(i);
      vectors++; if (count_out !== exp_c) begin miscompares++; $display("FAIL tick_%0d: got %h want %h", i, count_out, exp_c); end
    end
    tick = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    vectors++; if (count_out !== 24'h000000) begin miscompares++; $display("FAIL async_reset: got %h want 000000", count_out); end
    #1 rst_n = 1'b1;
    step();
  endtask

  task automatic test_wrap();
    apply_load(24'h235958, 1'b0);
    vectors++; if (count_out !== 24'h235958) begin miscompares++; $display("FAIL wrap_load: got %h want 235958", count_out); end
    tick = 1'b1;
    step();
    vectors++; if (count_out !== 24'h235959) begin miscompares++; $display("FAIL wrap_t1: got %h want 235959", count_out); end
    vectors++; if (carry_out !== 1'b0) begin miscompares++; $display("FAIL wrap_t1_carry: got %b want 0", carry_out); end
    step();
    tick = 1'b0;
    vectors++; if (count_out !== 24'h000000) begin miscompares++; $display("FAIL wrap_t2: got %h want 000000", count_out); end
    vectors++; if (carry_out !== 1'b1) begin miscompares++; $display("FAIL wrap_carry: got %b want 1", carry_out); end
    step();
    vectors++; if (carry_out !== 1'b0) begin miscompares++; $display("FAIL wrap_carry_end: got %b want 0", carry_out); end
    vectors++; if (count_out !== 24'h000000) begin miscompares++; $display("FAIL wrap_idle: got %h want 000000", count_out); end
  endtask

  task automatic test_load_reject();
    apply_load(24'h123456, 1'b0);
    vectors++; if (load_err !== 1'b0) begin miscompares++; $display("FAIL good_load_err: got %b want 0", load_err); end
    apply_load(24'h236000, 1'b0);
    vectors++; if (load_err !== 1'b1) begin miscompares++; $display("FAIL rej_min60_err: got %b want 1", load_err); end
    vectors++; if (count_out !== 24'h123456) begin miscompares++; $display("FAIL rej_min60_count: got %h want 123456", count_out); end
    step();
    vectors++; if (load_err !== 1'b0) begin miscompares++; $display("FAIL rej_min60_pulse: got %b want 0", load_err); end
    apply_load(24'h00001A, 1'b0);
    vectors++; if (load_err !== 1'b1) begin miscompares++; $display("FAIL rej_nibble_err: got %b want 1", load_err); end
    vectors++; if (count_out !== 24'h123456) begin miscompares++; $display("FAIL rej_nibble_count: got %h want 123456", count_out); end
    apply_load(24'h240000, 1'b1);
    vectors++; if (load_err !== 1'b1) begin miscompares++; $display("FAIL rej_hour24_err: got %b want 1", load_err); end
    vectors++; if (count_out !== 24'h123456) begin miscompares++; $display("FAIL rej_hour24_count: got %h want 123456", count_out); end
    step();
    vectors++; if (load_err !== 1'b0) begin miscompares++; $display("FAIL rej_hour24_pulse: got %b want 0", load_err); end
  endtask

  task automatic test_priority();
    apply_load(24'h120000, 1'b1);
    vectors++; if (count_out !== 24'h120000) begin miscompares++; $display("FAIL load_tick: got %h want 120000", count_out); end
    vectors++; if (carry_out !== 1'b0) begin miscompares++; $display("FAIL load_tick_carry: got %b want 0", carry_out); end
    hold = 1'b1;
    tick = 1'b1;
    for (int i = 0; i < 3; i++) step();
    tick = 1'b0;
    vectors++; if (count_out !== 24'h120000) begin miscompares++; $display("FAIL hold_ticks: got %h want 120000", count_out); end
    apply_load(24'h010203, 1'b1);
    vectors++; if (count_out !== 24'h010203) begin miscompares++; $display("FAIL hold_load: got %h want 010203", count_out); end
    hold = 1'b0;
  endtask

  task automatic test_ripple();
    apply_load(24'h000959, 1'b0);
    tick = 1'b1;
    step();
    tick = 1'b0;
    vectors++; if (count_out !== 24'h001000) begin miscompares++; $display("FAIL ripple_min: got %h want 001000", count_out); end
    apply_load(24'h095959, 1'b0);
    tick = 1'b1;
    step();
    tick = 1'b0;
    vectors++; if (count_out !== 24'h100000) begin miscompares++; $display("FAIL ripple_hour: got %h want 100000", count_out); end
    vectors++; if (carry_out !== 1'b0) begin miscompares++; $display("FAIL ripple_carry: got %b want 0", carry_out); end
  endtask

`ifdef COUNT_DOWN_EN
  task automatic test_count_down();
    dir = 1'b1;
    apply_load(24'h000000, 1'b0);
    tick = 1'b1;
    step();
    tick = 1'b0;
    vectors++; if (count_out !== 24'h235959) begin miscompares++; $display("FAIL down_wrap: got %h want 235959", count_out); end
    vectors++; if (carry_out !== 1'b1) begin miscompares++; $display("FAIL down_carry: got %b want 1", carry_out); end
    step();
    vectors++; if (carry_out !== 1'b0) begin miscompares++; $display("FAIL down_carry_end: got %b want 0", carry_out); end
    apply_load(24'h100000, 1'b0);
    tick = 1'b1;
    step();
    tick = 1'b0;
    vectors++; if (count_out !== 24'h095959) begin miscompares++; $display("FAIL down_borrow: got %h want 095959", count_out); end
    dir = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_wrap();
    test_load_reject();
    test_priority();
    test_ripple();
`ifdef COUNT_DOWN_EN
    test_count_down();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
